axi4_mem_slave_param: RTL and testbench
=======================================

AXI4_MEM_SLAVE_PARAM -- requirements
Module: axi4_mem_slave_param

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, 16, byte-address width of AWADDR/ARADDR.
- DATA_W, 32, data width in bits; legal values 32 or 64.
- MEM_DEPTH, 1024, number of DATA_W-bit memory words.
REQ-002 The block SHALL have these ports:
- ACLK  in  1  sole clock; all logic on rising edge.
- ARESET  in  1  synchronous active-high reset.
- AWADDR  in  ADDR_W  write burst start byte address.
- AWLEN  in  8  write beats minus one.
- AWSIZE  in  3  write beat size, log2 bytes.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  DATA_W  write data.
- WSTRB  in  DATA_W/8  byte enables.
- WLAST  in  1  last write beat marker.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  ADDR_W  read burst start byte address.
- ARLEN  in  8  read beats minus one.
- ARSIZE  in  3  read beat size, log2 bytes.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  DATA_W  read data.
- RRESP  out  2  read response.
- RLAST  out  1  last read beat.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.

Function
REQ-003 Storage SHALL be MEM_DEPTH words; word index = ADDR[ADDR_W-1:log2(DATA_W/8)], low address bits ignored; bursts are INCR only, +1 word per beat.
REQ-004 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP: AWREADY=1 only in W_IDLE; WREADY=1 only in W_DATA; BVALID=1 only in W_RESP.
REQ-005 On AW handshake the block SHALL capture address and AWLEN, clear beat counter, evaluate error, and enter W_DATA next cycle.
REQ-006 Each W handshake SHALL write only bytes with WSTRB set (if no error), increment word index and beat counter; the handshake with beat count == AWLEN SHALL move to W_RESP.
REQ-007 In W_RESP, BVALID SHALL hold with stable BRESP until BREADY=1, then return to W_IDLE.
REQ-008 Write error (BRESP=2'b10 SLVERR) SHALL be flagged if AWSIZE != log2(DATA_W/8), start word + AWLEN >= MEM_DEPTH, or WLAST is not asserted exactly on the final beat; errored bursts accept all data but SHALL NOT modify memory except beats already written before a WLAST mismatch is detected; else BRESP=2'b00.
REQ-009 Read FSM SHALL have states R_IDLE, R_DATA: ARREADY=1 only in R_IDLE; first RVALID one cycle after AR handshake.
REQ-010 RDATA/RRESP/RLAST SHALL be registered and held stable while RVALID=1 and RREADY=0; next beat is presented the cycle after each R handshake.
REQ-011 RLAST SHALL be 1 only on beat ARLEN; the R handshake on it SHALL return to R_IDLE.
REQ-012 Read error (ARSIZE illegal or start word + ARLEN >= MEM_DEPTH) SHALL produce ARLEN+1 beats with RDATA=0, RRESP=2'b10.
REQ-013 Read and write channels SHALL operate concurrently; same-word read and write in one cycle SHALL return pre-write data (read-first).

Reset
REQ-014 ARESET=1 on a clock edge SHALL force W_IDLE/R_IDLE, AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BRESP=0, RRESP=0, RDATA=0, clear counters; in-flight bursts abort mid-operation; memory contents SHALL be retained.

Verification
REQ-015 Write 0x0010, AWLEN=0, AWSIZE=2, WDATA=0xDEADBEEF, WSTRB=0xF -> BRESP=00; read 0x0010 -> RDATA=0xDEADBEEF, RLAST=1, RRESP=00.
REQ-016 Write 0x0100, AWLEN=3, data 1,2,3,4 -> read same returns 1,2,3,4, RLAST only on beat 4.
REQ-017 Overwrite 0xDEADBEEF with 0xAAAA5555, WSTRB=0x3 -> readback 0xDEAD5555.
REQ-018 AWADDR=0x0FFC, AWLEN=1 -> BRESP=10, word 1023 unchanged; ARSIZE=1 -> RRESP=10, RDATA=0.
REQ-019 RREADY held low 3 cycles mid-burst -> RDATA/RLAST stable; ARESET mid-burst -> RVALID=0 and ARREADY=1 next cycle.

Source files
------------

// File: rtl/axi4_mem_slave_param.sv
// AXI4 INCR-burst memory slave with independent read and write state machines.
// Wrong-size or out-of-range bursts complete normally but answer SLVERR and never touch memory.
module axi4_mem_slave_param #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 1024
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic [ADDR_W-1:0]   AWADDR,
   input  logic [7:0]          AWLEN,
   input  logic [2:0]          AWSIZE,
   input  logic                AWVALID,
   output logic                AWREADY,
   input  logic [DATA_W-1:0]   WDATA,
   input  logic [DATA_W/8-1:0] WSTRB,
   input  logic                WLAST,
   input  logic                WVALID,
   output logic                WREADY,
   output logic [1:0]          BRESP,
   output logic                BVALID,
   input  logic                BREADY,
   input  logic [ADDR_W-1:0]   ARADDR,
   input  logic [7:0]          ARLEN,
   input  logic [2:0]          ARSIZE,
   input  logic                ARVALID,
   output logic                ARREADY,
   output logic [DATA_W-1:0]   RDATA,
   output logic [1:0]          RRESP,
   output logic                RLAST,
   output logic                RVALID,
   input  logic                RREADY
);
   localparam int NB     = DATA_W / 8;
   localparam int OFF    = $clog2(NB);
   localparam int IDX_W  = ADDR_W - OFF;
   localparam int MEM_AW = $clog2(MEM_DEPTH);
   localparam logic [2:0] SIZE_OK = 3'(OFF);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

   logic [DATA_W-1:0] r_mem [MEM_DEPTH];

   wstate_t          r_wstate, w_wstate_nxt;
   logic [IDX_W-1:0] r_widx;
   logic [7:0]       r_wlen, r_wcnt;
   logic             r_werr;
   logic [1:0]       r_bresp;
   logic             w_aw_hs, w_w_hs, w_wfinal, w_wlast_bad, w_aw_err, w_we;

   rstate_t          r_rstate, w_rstate_nxt;
   logic [IDX_W-1:0] r_ridx, w_ar_idx, w_rnext;
   logic [7:0]       r_rlen, r_rcnt;
   logic             r_rerr, r_rlast;
   logic [DATA_W-1:0] r_rdata;
   logic [1:0]       r_rresp;
   logic             w_ar_hs, w_r_hs, w_ar_err;
   logic             w_unused;

   // Sub-word address bits carry no information for a full-width slave.
   assign w_unused = ^{AWADDR[OFF-1:0], ARADDR[OFF-1:0]};

   assign w_aw_hs     = AWVALID && AWREADY;
   assign w_w_hs      = WVALID && WREADY;
   assign w_wfinal    = (r_wcnt == r_wlen);
   assign w_wlast_bad = (WLAST != w_wfinal);
   assign w_aw_err    = (AWSIZE != SIZE_OK) ||
                        (32'(AWADDR[ADDR_W-1:OFF]) + 32'(AWLEN) >= 32'(MEM_DEPTH));
   // A WLAST mismatch poisons the current beat and everything after it.
   assign w_we        = w_w_hs && !r_werr && !w_wlast_bad && !ARESET;
   assign BRESP       = r_bresp;

   always_ff @(posedge ACLK) begin
      if (ARESET) r_wstate <= W_IDLE;
      else        r_wstate <= w_wstate_nxt;
   end

   always_comb begin
      w_wstate_nxt = r_wstate;
      AWREADY      = 1'b0;
      WREADY       = 1'b0;
      BVALID       = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            AWREADY = 1'b1;
            if (AWVALID) w_wstate_nxt = W_DATA;
         end
         W_DATA: begin
            WREADY = 1'b1;
            if (WVALID && w_wfinal) w_wstate_nxt = W_RESP;
         end
         W_RESP: begin
            BVALID = 1'b1;
            if (BREADY) w_wstate_nxt = W_IDLE;
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_widx  <= '0;
         r_wlen  <= '0;
         r_wcnt  <= '0;
         r_werr  <= 1'b0;
         r_bresp <= 2'b00;
      end else begin
         if (w_aw_hs) begin
            r_widx <= AWADDR[ADDR_W-1:OFF];
            r_wlen <= AWLEN;
            r_wcnt <= '0;
            r_werr <= w_aw_err;
         end
         if (w_w_hs) begin
            r_widx <= r_widx + 1'b1;
            r_wcnt <= r_wcnt + 1'b1;
            r_werr <= r_werr | w_wlast_bad;
            if (w_wfinal) r_bresp <= (r_werr || w_wlast_bad) ? 2'b10 : 2'b00;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (w_we)
         for (int b = 0; b < NB; b++)
            if (WSTRB[b]) r_mem[r_widx[MEM_AW-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
   end

   assign w_ar_hs  = ARVALID && ARREADY;
   assign w_r_hs   = RVALID && RREADY;
   assign w_ar_idx = ARADDR[ADDR_W-1:OFF];
   assign w_rnext  = r_ridx + 1'b1;
   assign w_ar_err = (ARSIZE != SIZE_OK) ||
                     (32'(ARADDR[ADDR_W-1:OFF]) + 32'(ARLEN) >= 32'(MEM_DEPTH));
   assign RDATA    = r_rdata;
   assign RRESP    = r_rresp;
   assign RLAST    = r_rlast;

   always_ff @(posedge ACLK) begin
      if (ARESET) r_rstate <= R_IDLE;
      else        r_rstate <= w_rstate_nxt;
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      ARREADY      = 1'b0;
      RVALID       = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            ARREADY = 1'b1;
            if (ARVALID) w_rstate_nxt = R_DATA;
         end
         R_DATA: begin
            RVALID = 1'b1;
            if (RREADY && r_rlast) w_rstate_nxt = R_IDLE;
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   // Memory reads land on the same edge as writes, so a colliding read sees old data.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_ridx  <= '0;
         r_rlen  <= '0;
         r_rcnt  <= '0;
         r_rerr  <= 1'b0;
         r_rdata <= '0;
         r_rresp <= 2'b00;
         r_rlast <= 1'b0;
      end else if (w_ar_hs) begin
         r_ridx  <= w_ar_idx;
         r_rlen  <= ARLEN;
         r_rcnt  <= '0;
         r_rerr  <= w_ar_err;
         r_rdata <= w_ar_err ? '0 : r_mem[w_ar_idx[MEM_AW-1:0]];
         r_rresp <= w_ar_err ? 2'b10 : 2'b00;
         r_rlast <= (ARLEN == 8'd0);
      end else if (w_r_hs) begin
         if (r_rlast) begin
            r_rlast <= 1'b0;
         end else begin
            r_ridx  <= w_rnext;
            r_rcnt  <= r_rcnt + 1'b1;
            r_rdata <= r_rerr ? '0 : r_mem[w_rnext[MEM_AW-1:0]];
            r_rlast <= (r_rcnt + 8'd1 == r_rlen);
         end
      end
   end
endmodule

// File: tb/tb_axi4_mem_slave_param.sv
// Bench for axi4_mem_slave_param: vector table, directed corner sequences, and
// randomized bursts checked against a word-array memory model.
module tb_axi4_mem_slave_param;
   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic [15:0] AWADDR = '0;
   logic [7:0]  AWLEN = '0;
   logic [2:0]  AWSIZE = '0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] WDATA = '0;
   logic [3:0]  WSTRB = '0;
   logic        WLAST = 1'b0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY = 1'b0;
   logic [15:0] ARADDR = '0;
   logic [7:0]  ARLEN = '0;
   logic [2:0]  ARSIZE = '0;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY = 1'b0;

   axi4_mem_slave_param dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   int n_pass = 0;
   int n_tot  = 0;

   logic [31:0] mdl   [1024];
   logic [31:0] wbuf  [256];
   logic [3:0]  sbuf  [256];
   logic [31:0] rbuf  [256];
   logic [1:0]  rrbuf [256];
   logic        rlbuf [256];

   typedef struct {
      logic [15:0] waddr; logic [2:0] wsize; logic [31:0] wdata; logic [3:0] wstrb; logic [1:0] exp_b;
      logic [15:0] raddr; logic [2:0] rsize; logic [31:0] exp_d; logic [1:0] exp_r;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
   endtask

   // All tasks start and end on a falling edge.
   task automatic do_write(input logic [15:0] addr, input int len, input logic [2:0] size,
                           input int lastpos, input bit gaps,
                           output logic [1:0] bresp, output logic [1:0] exp_b);
      int t; int start; bit err;
      AWADDR = addr; AWLEN = 8'(len); AWSIZE = size; AWVALID = 1'b1;
      t = 0;
      while (!AWREADY && t < 50) begin @(negedge ACLK); t++; end
      chk("awready", AWREADY, 1'b1);
      @(negedge ACLK);
      AWVALID = 1'b0;
      for (int i = 0; i <= len; i++) begin
         if (gaps) repeat ($urandom_range(0, 1)) @(negedge ACLK);
         WDATA = wbuf[i]; WSTRB = sbuf[i]; WLAST = (i == lastpos); WVALID = 1'b1;
         t = 0;
         while (!WREADY && t < 50) begin @(negedge ACLK); t++; end
         chk("wready", WREADY, 1'b1);
         @(negedge ACLK);
         WVALID = 1'b0; WLAST = 1'b0;
      end
      t = 0;
      while (!BVALID && t < 50) begin @(negedge ACLK); t++; end
      chk("bvalid", BVALID, 1'b1);
      bresp = BRESP;
      if (gaps) repeat ($urandom_range(0, 2)) begin
         @(negedge ACLK);
         chk("bresp_hold", BRESP, bresp);
      end
      BREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0;
      start = int'(addr[15:2]);
      err = (size != 3'd2) || (start + len >= 1024);
      for (int i = 0; i <= len; i++) begin
         if ((i == lastpos) != (i == len)) err = 1'b1;
         if (!err)
            for (int b = 0; b < 4; b++)
               if (sbuf[i][b]) mdl[start+i][b*8 +: 8] = wbuf[i][b*8 +: 8];
      end
      exp_b = err ? 2'b10 : 2'b00;
   endtask

   task automatic do_read(input logic [15:0] addr, input int len, input logic [2:0] size,
                          input int stall_beat, input int stall_n, input bit rnd_stall);
      int t; int n;
      ARADDR = addr; ARLEN = 8'(len); ARSIZE = size; ARVALID = 1'b1;
      t = 0;
      while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
      chk("arready", ARREADY, 1'b1);
      @(negedge ACLK);
      ARVALID = 1'b0;
      for (int i = 0; i <= len; i++) begin
         chk("rvalid", RVALID, 1'b1);
         rbuf[i] = RDATA; rrbuf[i] = RRESP; rlbuf[i] = RLAST;
         n = (i == stall_beat) ? stall_n : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
         RREADY = 1'b0;
         repeat (n) begin
            @(negedge ACLK);
            chk("rdata_hold", RDATA, rbuf[i]);
            chk("rlast_hold", RLAST, rlbuf[i]);
         end
         RREADY = 1'b1;
         @(negedge ACLK);
         RREADY = 1'b0;
      end
      chk("rvalid_end", RVALID, 1'b0);
   endtask

   task automatic rd_chk(input logic [15:0] addr, input int len, input logic [2:0] size, input string tag);
      int start; bit err;
      start = int'(addr[15:2]);
      err = (size != 3'd2) || (start + len >= 1024);
      for (int i = 0; i <= len; i++) begin
         if (err) chk({tag, "_data"}, rbuf[i], 32'h0);
         else     chk({tag, "_data"}, rbuf[i], mdl[start+i]);
         chk({tag, "_resp"}, rrbuf[i], err ? 2'b10 : 2'b00);
         chk({tag, "_last"}, rlbuf[i], i == len);
      end
   endtask

   initial begin
      logic [1:0] b, eb;
      logic [31:0] old;
      tbl[0] = '{16'h0010, 3'd2, 32'hDEADBEEF, 4'hF, 2'b00, 16'h0010, 3'd2, 32'hDEADBEEF, 2'b00};
      tbl[1] = '{16'h0010, 3'd2, 32'hAAAA5555, 4'h3, 2'b00, 16'h0010, 3'd2, 32'hDEAD5555, 2'b00};
      tbl[2] = '{16'h0012, 3'd2, 32'h11223344, 4'hC, 2'b00, 16'h0010, 3'd2, 32'h11225555, 2'b00};
      tbl[3] = '{16'h0010, 3'd1, 32'hFFFFFFFF, 4'hF, 2'b10, 16'h0010, 3'd2, 32'h11225555, 2'b00};
      tbl[4] = '{16'h0FFC, 3'd2, 32'hCAFEF00D, 4'hF, 2'b00, 16'h0FFC, 3'd2, 32'hCAFEF00D, 2'b00};
      tbl[5] = '{16'h0FFC, 3'd3, 32'h12345678, 4'hF, 2'b10, 16'h0FFC, 3'd1, 32'h00000000, 2'b10};

      repeat (3) @(negedge ACLK);
      ARESET = 1'b0;
      chk("rst_awready", AWREADY, 1'b1);
      chk("rst_arready", ARREADY, 1'b1);
      chk("rst_wready", WREADY, 1'b0);
      chk("rst_bvalid", BVALID, 1'b0);
      chk("rst_rvalid", RVALID, 1'b0);
      chk("rst_rlast", RLAST, 1'b0);
      chk("rst_bresp", BRESP, 2'b00);
      chk("rst_rresp", RRESP, 2'b00);
      chk("rst_rdata", RDATA, 32'h0);

      // Fill the whole memory so the model is fully known.
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
         do_write(16'(k * 1024), 255, 3'd2, 255, 1'b0, b, eb);
         chk("init_bresp", b, 2'b00);
      end

      for (int v = 0; v < 6; v++) begin
         wbuf[0] = tbl[v].wdata; sbuf[0] = tbl[v].wstrb;
         do_write(tbl[v].waddr, 0, tbl[v].wsize, 0, 1'b0, b, eb);
         chk("tbl_bresp", b, tbl[v].exp_b);
         do_read(tbl[v].raddr, 0, tbl[v].rsize, -1, 0, 1'b0);
         chk("tbl_rdata", rbuf[0], tbl[v].exp_d);
         chk("tbl_rresp", rrbuf[0], tbl[v].exp_r);
         chk("tbl_rlast", rlbuf[0], 1'b1);
      end

      // Four-beat burst, read back with a three-cycle stall on beat 1.
      for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
      do_write(16'h0100, 3, 3'd2, 3, 1'b0, b, eb);
      chk("burst_bresp", b, 2'b00);
      do_read(16'h0100, 3, 3'd2, 1, 3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("burst_data", rbuf[i], 32'(i + 1));
         chk("burst_last", rlbuf[i], i == 3);
         chk("burst_resp", rrbuf[i], 2'b00);
      end

      // Burst running past the end of memory.
      wbuf[0] = 32'h55555555; wbuf[1] = 32'h66666666; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
      do_write(16'h0FFC, 1, 3'd2, 1, 1'b0, b, eb);
      chk("oob_bresp", b, 2'b10);
      do_read(16'h0FFC, 0, 3'd2, -1, 0, 1'b0);
      chk("oob_word1023", rbuf[0], 32'hCAFEF00D);
      do_read(16'h0FFC, 1, 3'd2, -1, 0, 1'b0);
      rd_chk(16'h0FFC, 1, 3'd2, "oob_rd");

      // WLAST too early, then never asserted.
      for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
      do_write(16'h0200, 3, 3'd2, 1, 1'b0, b, eb);
      chk("wlast_early_bresp", b, 2'b10);
      do_read(16'h0200, 3, 3'd2, -1, 0, 1'b0);
      chk("wlast_early_beat0", rbuf[0], 32'hA0);
      rd_chk(16'h0200, 3, 3'd2, "wlast_early");
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0 + 32'(i);
      do_write(16'h0300, 3, 3'd2, 9, 1'b0, b, eb);
      chk("wlast_miss_bresp", b, 2'b10);
      do_read(16'h0300, 3, 3'd2, -1, 0, 1'b0);
      rd_chk(16'h0300, 3, 3'd2, "wlast_miss");

      // Read and write of the same word on the same edge.
      AWADDR = 16'h0400; AWLEN = 8'd0; AWSIZE = 3'd2; AWVALID = 1'b1;
      chk("rf_awready", AWREADY, 1'b1);
      @(negedge ACLK);
      AWVALID = 1'b0;
      WDATA = 32'h5A5A0F0F; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
      ARADDR = 16'h0400; ARLEN = 8'd0; ARSIZE = 3'd2; ARVALID = 1'b1;
      chk("rf_wready", WREADY, 1'b1);
      chk("rf_arready", ARREADY, 1'b1);
      old = mdl[256];
      @(negedge ACLK);
      WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0;
      chk("rf_rvalid", RVALID, 1'b1);
      chk("rf_rdata_old", RDATA, old);
      chk("rf_bvalid", BVALID, 1'b1);
      chk("rf_bresp", BRESP, 2'b00);
      RREADY = 1'b1; BREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0; BREADY = 1'b0;
      mdl[256] = 32'h5A5A0F0F;
      do_read(16'h0400, 0, 3'd2, -1, 0, 1'b0);
      rd_chk(16'h0400, 0, 3'd2, "rf_new");

      // Reset in the middle of a read burst and a write burst.
      ARADDR = 16'h0100; ARLEN = 8'd3; ARSIZE = 3'd2; ARVALID = 1'b1;
      @(negedge ACLK);
      ARVALID = 1'b0; RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0;
      chk("mid_rvalid", RVALID, 1'b1);
      chk("mid_rdata", RDATA, 32'd2);
      AWADDR = 16'h0600; AWLEN = 8'd3; AWSIZE = 3'd2; AWVALID = 1'b1;
      @(negedge ACLK);
      AWVALID = 1'b0;
      WDATA = 32'hC0C0C0C0; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
      @(negedge ACLK);
      WDATA = 32'hC1C1C1C1;
      @(negedge ACLK);
      WVALID = 1'b0;
      mdl[384] = 32'hC0C0C0C0; mdl[385] = 32'hC1C1C1C1;
      ARESET = 1'b1;
      @(negedge ACLK);
      ARESET = 1'b0;
      chk("arst_rvalid", RVALID, 1'b0);
      chk("arst_arready", ARREADY, 1'b1);
      chk("arst_rlast", RLAST, 1'b0);
      chk("arst_rdata", RDATA, 32'h0);
      chk("arst_awready", AWREADY, 1'b1);
      chk("arst_wready", WREADY, 1'b0);
      chk("arst_bvalid", BVALID, 1'b0);
      do_read(16'h0100, 3, 3'd2, -1, 0, 1'b0);
      rd_chk(16'h0100, 3, 3'd2, "retain_rd");
      do_read(16'h0600, 3, 3'd2, -1, 0, 1'b0);
      rd_chk(16'h0600, 3, 3'd2, "retain_wr");

      for (int it = 0; it < 60; it++) begin
         int word; int len; int lastpos; logic [15:0] addr; logic [2:0] size;
         word = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1010, 1023)) : int'($urandom_range(0, 1023));
         addr = 16'(word * 4 + int'($urandom_range(0, 3)));
         len  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(8, 20)) : int'($urandom_range(0, 7));
         size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
         if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
            lastpos = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len + 1)) : len;
            do_write(addr, len, size, lastpos, 1'b1, b, eb);
            chk("rnd_bresp", b, eb);
         end else begin
            do_read(addr, len, size, -1, 0, 1'b1);
            rd_chk(addr, len, size, "rnd_rd");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
